// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB).
// Merges per-stage stall requests into one hold vector, sequences multi-cycle
// EX operations with a bounded wait, and turns committed exceptions into a
// one-cycle flush with a redirect PC. Also keeps a saturating count of cycles
// in which the IF stage was held.

module pipe_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             exc_req,
    input  logic [31:0]      exc_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_abort,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    // The wait counter only has to reach MC_TIMEOUT-1, so it never wraps.
    localparam int WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Stall vector: a request from stage k holds stage k and everything in front of it.
    always_comb begin
        stall = 6'b000000;
        if (state == FLUSH) begin
            stall = 6'b000000;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if ((state == MC_WAIT && !mc_done) || stallreq_ex ||
                     (state == RUN && mc_start)) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else if (stallreq_if) begin
            stall = 6'b000011;
        end
    end

    // Flush comes straight off the state register so it cannot glitch.
    assign flush = (state == FLUSH);

    // Controller FSM with registered pulse outputs and redirect address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            new_pc     <= 32'h0000_0000;
            mc_abort   <= 1'b0;
            mc_timeout <= 1'b0;
        end else begin
            mc_abort   <= 1'b0;
            mc_timeout <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_req) begin
                        state  <= FLUSH;
                        new_pc <= exc_vector;
                    end else if (mc_start) begin
                        state    <= MC_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MC_WAIT: begin
                    if (exc_req) begin
                        state    <= FLUSH;
                        new_pc   <= exc_vector;
                        mc_abort <= 1'b1;
                    end else if (mc_done) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= RUN;
                        mc_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which IF was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (stall[1] && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Directed vectors for pipe_stall_ctrl. The stimulus process pushes the
// hand-computed expected outputs for each cycle into a queue; a monitor
// pops one entry per cycle on the falling edge and compares.

module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        mc_start;
    logic        mc_done;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_abort;
    logic        mc_timeout;
    logic [31:0] stall_cycles;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        abort;
        logic        tmo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cyc;

    pipe_stall_ctrl #(
        .MC_TIMEOUT(64),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .mc_start    (mc_start),
        .mc_done     (mc_done),
        .exc_req     (exc_req),
        .exc_vector  (exc_vector),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .mc_abort    (mc_abort),
        .mc_timeout  (mc_timeout),
        .stall_cycles(stall_cycles)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's worth of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic r, input logic sif, input logic sid,
                                 input logic sex, input logic smem, input logic st,
                                 input logic dn, input logic ex, input logic [31:0] vec);
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_if  = sif;
        stallreq_id  = sid;
        stallreq_ex  = sex;
        stallreq_mem = smem;
        mc_start     = st;
        mc_done      = dn;
        exc_req      = ex;
        exc_vector   = vec;
    endtask

    // Queue the expected outputs for the current cycle and advance the counter model.
    task automatic checkOutput(input string name, input logic [5:0] s, input logic f,
                               input logic ab, input logic tm);
        exp_t e;
        e.name   = name;
        e.stall  = s;
        e.flush  = f;
        e.new_pc = model_pc;
        e.abort  = ab;
        e.tmo    = tm;
        e.cyc    = model_cyc;
        expq.push_back(e);
        if (s[1] && model_cyc != 32'hFFFF_FFFF) model_cyc = model_cyc + 32'd1;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                compareField(e.name, "stall", {26'd0, stall}, {26'd0, e.stall});
                compareField(e.name, "flush", {31'd0, flush}, {31'd0, e.flush});
                compareField(e.name, "new_pc", new_pc, e.new_pc);
                compareField(e.name, "mc_abort", {31'd0, mc_abort}, {31'd0, e.abort});
                compareField(e.name, "mc_timeout", {31'd0, mc_timeout}, {31'd0, e.tmo});
                compareField(e.name, "stall_cycles", stall_cycles, e.cyc);
            end
        end
    end

    // Directed sequence
    initial begin
        int wait_budget;
        rst = 1'b0; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        stallreq_mem = 1'b0; mc_start = 1'b0; mc_done = 1'b0; exc_req = 1'b0;
        exc_vector = 32'h0;
        model_pc  = 32'h0;
        model_cyc = 32'h0;
        checkOutput("reset", 6'b000000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("release", 6'b000000, 0, 0, 0);

        // individual stall requests, then combined
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("req_if", 6'b000011, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 32'h0); checkOutput("req_id", 6'b000111, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 32'h0); checkOutput("req_mem", 6'b011111, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 1, 0, 0, 0, 32'h0); checkOutput("req_all", 6'b011111, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 32'h0); checkOutput("req_ex", 6'b001111, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("idle0", 6'b000000, 0, 0, 0);

        // multi-cycle op completing with mc_done five cycles after mc_start
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h0); checkOutput("mc_start", 6'b001111, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
            checkOutput("mc_wait", 6'b001111, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 32'h0); checkOutput("mc_done", 6'b000000, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("after_done", 6'b000000, 0, 0, 0);

        // mc_start with stallreq_mem still enters MC_WAIT
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 32'h0); checkOutput("start_mem", 6'b011111, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("start_mem_wait", 6'b001111, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 32'h0); checkOutput("start_mem_done", 6'b000000, 0, 0, 0);

        // timeout: mc_start cycle plus 64 MC_WAIT cycles, mem request midway
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h0); checkOutput("tmo_start", 6'b001111, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1, 0, 0, 0, (i == 9), 0, 0, 0, 32'h0);
            checkOutput("tmo_wait", (i == 9) ? 6'b011111 : 6'b001111, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("tmo_pulse", 6'b000000, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("tmo_after", 6'b000000, 0, 0, 0);

        // exception during MC_WAIT at counter 3
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h0); checkOutput("exc_start", 6'b001111, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
            checkOutput("exc_wait", 6'b001111, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0020); checkOutput("exc_req", 6'b001111, 0, 0, 0);
        model_pc = 32'h0000_0020;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("exc_flush", 6'b000000, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("exc_run", 6'b000000, 0, 0, 0);

        // exc_req held two cycles from RUN; mem request during flush is masked
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0040); checkOutput("exc2_a", 6'b000000, 0, 0, 0);
        model_pc = 32'h0000_0040;
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0080); checkOutput("exc2_flush", 6'b000000, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("exc2_run", 6'b000000, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("exc2_idle", 6'b000000, 0, 0, 0);

        // asynchronous reset in MC_WAIT at counter 10
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h0); checkOutput("rst_start", 6'b001111, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
            checkOutput("rst_wait", 6'b001111, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        model_pc  = 32'h0;
        model_cyc = 32'h0;
        checkOutput("rst_async", 6'b000000, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("rst_release", 6'b000000, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("rst_req_if", 6'b000011, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0); checkOutput("rst_count", 6'b000000, 0, 0, 0);

        wait_budget = 0;
        while (expq.size() > 0 && wait_budget < 10) begin
            @(posedge clk);
            wait_budget++;
        end
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 6-stage core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the 6-bit stall vector consumed by all pipeline registers, including the IF/ID register.
- Sequences multi-cycle EX operations (divide, multiply-accumulate) with a start/done handshake and timeout.
- Sequences exception flushes: a one-cycle flush pulse plus a redirect PC.

Parameters:
- MC_TIMEOUT, 64, maximum cycles spent in MC_WAIT before forced release.
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low (rst==0 resets immediately, independent of clk).
- stallreq_if  input  1  fetch waiting on instruction bus.
- stallreq_id  input  1  load-use hazard detected in ID.
- stallreq_ex  input  1  single-cycle EX hold request.
- stallreq_mem  input  1  data bus wait.
- mc_start  input  1  EX begins a multi-cycle op (1-cycle pulse).
- mc_done  input  1  multi-cycle unit result valid.
- exc_req  input  1  exception/interrupt committed in MEM.
- exc_vector  input  32  handler address for exc_req.
- stall  output  6  bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1=hold.
- flush  output  1  clear all pipeline registers.
- new_pc  output  32  redirect address, valid while flush=1.
- mc_abort  output  1  cancels in-flight multi-cycle op (1-cycle pulse).
- mc_timeout  output  1  multi-cycle op timed out (1-cycle pulse).
- stall_cycles  output  CNT_W  count of cycles with stall[1]=1, saturating.

Behaviour:
- States: RUN, MC_WAIT, FLUSH. State register, wait counter, new_pc, mc_abort, mc_timeout and stall_cycles are registered.
- Reset values: state=RUN, counter=0, new_pc=0, mc_abort=0, mc_timeout=0, stall_cycles=0. flush=0 and stall=000000 follow from state RUN.
- stall is combinational from state and inputs. It is evaluated in this priority order:
  - state==FLUSH -> 000000.
  - stallreq_mem -> 011111.
  - (state==MC_WAIT and !mc_done), or stallreq_ex, or (state==RUN and mc_start) -> 001111.
  - stallreq_id -> 000111.
  - stallreq_if -> 000011.
  - otherwise -> 000000.
- Invariant: stall bit k set implies all bits below k are set.
- flush = (state==FLUSH); flush is glitch-free, directly decoded from the state register.
- Transitions:
  - RUN:
    - exc_req -> FLUSH; new_pc<=exc_vector.
    - else mc_start -> MC_WAIT; counter<=0.
    - else stay in RUN.
  - MC_WAIT:
    - exc_req -> FLUSH; new_pc<=exc_vector; mc_abort<=1.
    - else mc_done -> RUN; stall released in the same cycle as mc_done.
    - else counter==MC_TIMEOUT-1 -> RUN; mc_timeout<=1.
    - else counter increments.
  - FLUSH: always -> RUN after exactly one cycle. exc_req arriving during FLUSH is ignored; the flush clears the source.
- Latency: exc_req sampled at edge N gives flush=1 for the cycle after edge N, and RUN at edge N+1.
- mc_abort and mc_timeout are high for exactly one cycle and otherwise 0.
- stallreq_mem during MC_WAIT raises stall to 011111 but does not change the state or freeze the counter.
- mc_start while stallreq_mem=1 in RUN still enters MC_WAIT.
- stall_cycles increments on each edge where stall[1]=1 and holds at all-ones on saturation.
- Reset assertion mid-operation (any state) returns to RUN immediately. Outputs take their reset values asynchronously.

Test Plan:
- Reset with rst=0 mid-MC_WAIT at counter=10 -> state RUN, stall=000000, flush=0, new_pc=0, stall_cycles=0 before the next clk edge.
- stallreq_if, stallreq_id, stallreq_mem asserted one at a time, then all three together -> stall=000011, 000111, 011111, then 011111.
- mc_start at cycle 0, mc_done at cycle 5 -> stall=001111 for cycles 0-4, 000000 at cycle 5, stall_cycles=5.
- mc_start with mc_done never asserted, MC_TIMEOUT=64 -> stall=001111 for 64 cycles, mc_timeout=1 for one cycle, then stall=000000.
- exc_req with exc_vector=0x00000020 at cycle 3 of MC_WAIT -> next cycle flush=1, new_pc=0x00000020, stall=000000, mc_abort=1; the following cycle flush=0, state RUN.
- exc_req held high for 2 cycles from RUN -> flush=1 for exactly one cycle, then RUN; no second flush pulse.
